alu_issue_ctrl: RTL and testbench
=================================

Name: alu_issue_ctrl

Overview:
Sequencing front end for the 16-bit combinational ALU. Accepts one operation request per valid/ready handshake and evaluates a 4-bit condition code against its architectural NZCV flag register. If the condition passes, it drives the ALU, captures the result and flags, and optionally updates NZCV. It returns a response over a second valid/ready handshake and sits between the decode stage and the ALU.

Parameters:
N, 16, datapath width; must match the ALU width.

Ports:
clk  input  1  single clock, rising edge
rst_n  input  1  asynchronous active-low reset
req_valid  input  1  request present
req_ready  output  1  block can accept a request
req_op  input  3  ALU ctrl code (000 add, 001 sub, 010 pass A, 011 pass B, 100 mod, 101 and, 110 mul, 111 shr)
req_a  input  N  operand A
req_b  input  N  operand B
req_cond  input  4  condition code
req_setflags  input  1  update NZCV on execution
rsp_valid  output  1  response present
rsp_ready  input  1  consumer accepts response
rsp_res  output  N  result; 0 when skipped
rsp_exec  output  1  1 = condition passed and the operation executed
rsp_flags  output  4  ALU flags of this operation; current NZCV if skipped
nzcv  output  4  flag register: 3=N, 2=Z, 1=C, 0=V
alu_a  output  N  to ALU a
alu_b  output  N  to ALU b
alu_ctrl  output  3  to ALU ctrl
alu_res  input  N  from ALU res
alu_flags  input  4  from ALU flags (3=N, 2=Z, 1=C, 0=V)

Behaviour:
- Reset (async, rst_n=0): state IDLE; req_ready=1; rsp_valid=0; rsp_res=0; rsp_exec=0; rsp_flags=0; nzcv=0000; alu_a=0; alu_b=0; alu_ctrl=000.
- All outputs are registered. alu_* hold their values between operations.
- FSM states are IDLE, EXEC and RESP.
- IDLE:
  - req_ready=1.
  - On req_valid, latch the request and evaluate req_cond against the current nzcv.
  - Pass: load alu_a, alu_b and alu_ctrl, then go to EXEC.
  - Fail: rsp_res=0, rsp_exec=0, rsp_flags=nzcv, then go to RESP.
- EXEC (exactly 1 cycle):
  - req_ready=0; the ALU settles combinationally.
  - At the closing edge, capture rsp_res=alu_res, rsp_flags=alu_flags and rsp_exec=1.
  - If the latched setflags=1, also set nzcv=alu_flags.
  - Go to RESP.
- RESP:
  - rsp_valid=1; req_ready=0.
  - Response fields are held stable until rsp_valid && rsp_ready; then rsp_valid=0 and the FSM returns to IDLE.
  - No new request is accepted in the handshake cycle.
- Latency, accept edge to rsp_valid: 2 cycles when executed, 1 cycle when skipped. Throughput is at most one request per 3 cycles (2 when skipped).
- Conditions:
  - 0000 EQ Z; 0001 NE !Z; 0010 CS C; 0011 CC !C; 0100 MI N; 0101 PL !N; 0110 VS V; 0111 VC !V.
  - 1000 HI C&!Z; 1001 LS !C|Z; 1010 GE N==V; 1011 LT N!=V; 1100 GT !Z&(N==V); 1101 LE Z|(N!=V); 1110 AL always; 1111 NV never.
- Conditions are always evaluated against nzcv before this operation's update.
- Skipped operations never modify nzcv, regardless of setflags.
- req_* are ignored outside IDLE. The block does not check mod-by-zero; the result is whatever the ALU returns.
- Reset asserted in any state aborts the operation: no response is produced and the reset values above apply immediately.

Optional Feature:
ALU_ISSUE_PERF_EN:
- Defined: adds output ports cnt_exec [15:0] and cnt_skip [15:0], reset to 0.
- cnt_exec increments at EXEC exit; cnt_skip increments on accept of a failing condition.
- Both counters saturate at 0xFFFF.
- Undefined: the ports and logic are absent; all other behaviour is identical.

Test Plan:
1. Reset then release -> req_ready=1, rsp_valid=0, nzcv=0000, alu_ctrl=000.
2. op=000, a=0x7FFF, b=0x0001, cond=1110, setflags=1 -> rsp_valid at accept+2, rsp_res=0x8000, rsp_exec=1, rsp_flags=1001, nzcv=1001.
3. Next: op=000, cond=0000 (EQ, Z=0) -> rsp_valid at accept+1, rsp_exec=0, rsp_res=0, rsp_flags=1001, nzcv stays 1001, alu_* unchanged.
4. op=001, a=5, b=5, cond=1110, setflags=1 -> rsp_res=0, nzcv=0110. Then op=101, a=0x00F0, b=0x0FF0, cond=0000 (EQ passes), setflags=0 -> rsp_res=0x00F0, rsp_exec=1, rsp_flags=0000, nzcv stays 0110.
5. rsp_ready=0 for 5 cycles during RESP, with req_valid=1 and changing req_a -> rsp_valid and all rsp_* stable, req_ready=0, no second accept. Raise rsp_ready -> return to IDLE the next cycle.
6. Assert rst_n=0 during EXEC -> no rsp_valid, nzcv=0000 immediately, req_ready=1 after release.

Source files
------------

// File: rtl/alu_issue_ctrl.sv
// -----------------------------------------------------------------------------
// alu_issue_ctrl
//
// Sequencing front end for the N-bit combinational ALU. A request is accepted
// over a valid/ready handshake, its 4-bit condition code is evaluated against
// the architectural NZCV register and, if the condition passes, the operands
// are driven to the ALU for one cycle. The result is then returned over a
// second valid/ready handshake. Failing conditions skip the ALU and return a
// zero result with the current NZCV.
//
// Optional feature macro: ALU_ISSUE_PERF_EN
//   When defined, adds saturating 16-bit counters cnt_exec and cnt_skip.
//
// Ports:
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   req_valid/ready   request handshake
//   req_op/a/b        ALU control code and operands
//   req_cond          condition code evaluated against nzcv
//   req_setflags      update nzcv with the ALU flags when executed
//   rsp_valid/ready   response handshake
//   rsp_res           ALU result (0 when skipped)
//   rsp_exec          1 when the condition passed and the operation ran
//   rsp_flags         ALU flags of this operation, or nzcv when skipped
//   nzcv              architectural flag register {N,Z,C,V}
//   alu_a/b/ctrl      operands and control towards the ALU (held between ops)
//   alu_res/flags     result and flags returned by the ALU
//   cnt_exec/skip     executed / skipped operation counters (macro only)
// -----------------------------------------------------------------------------
module alu_issue_ctrl #(
    parameter int N = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic [2:0]   req_op,
    input  logic [N-1:0] req_a,
    input  logic [N-1:0] req_b,
    input  logic [3:0]   req_cond,
    input  logic         req_setflags,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic [N-1:0] rsp_res,
    output logic         rsp_exec,
    output logic [3:0]   rsp_flags,
    output logic [3:0]   nzcv,
    output logic [N-1:0] alu_a,
    output logic [N-1:0] alu_b,
    output logic [2:0]   alu_ctrl,
    input  logic [N-1:0] alu_res,
    input  logic [3:0]   alu_flags
`ifdef ALU_ISSUE_PERF_EN
    ,
    output logic [15:0]  cnt_exec,
    output logic [15:0]  cnt_skip
`endif
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_EXEC = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    logic [1:0] state_r;
    logic [1:0] state_nxt_s;
    logic       setflags_r;
    logic       cond_pass_s;

    // Condition evaluation. Codes come in pairs where the odd code is the
    // inverse of the even one (AL/NV included), so evaluate the even-code
    // predicate and flip it with bit 0.
    function automatic logic cond_check(input logic [3:0] cond, input logic [3:0] f);
        logic n, z, c, v, r;
        n = f[3];
        z = f[2];
        c = f[1];
        v = f[0];
        case (cond[3:1])
            3'd0:    r = z;
            3'd1:    r = c;
            3'd2:    r = n;
            3'd3:    r = v;
            3'd4:    r = c & ~z;
            3'd5:    r = (n == v);
            3'd6:    r = ~z & (n == v);
            default: r = 1'b1;
        endcase
        return r ^ cond[0];
    endfunction

    // Condition result for the request currently offered, against present nzcv
    always_comb begin
        cond_pass_s = cond_check(req_cond, nzcv);
    end

    // Next-state logic of the issue FSM
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (req_valid) begin
                    if (cond_pass_s) begin
                        state_nxt_s = ST_EXEC;
                    end else begin
                        state_nxt_s = ST_RESP;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_EXEC: begin
                state_nxt_s = ST_RESP;
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_RESP;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // State, handshake flags, ALU drive, response capture and nzcv update
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            setflags_r <= 1'b0;
            req_ready  <= 1'b1;
            rsp_valid  <= 1'b0;
            rsp_res    <= {N{1'b0}};
            rsp_exec   <= 1'b0;
            rsp_flags  <= 4'b0000;
            nzcv       <= 4'b0000;
            alu_a      <= {N{1'b0}};
            alu_b      <= {N{1'b0}};
            alu_ctrl   <= 3'b000;
        end else begin
            state_r   <= state_nxt_s;
            // Handshake flags are registered copies of the next state
            req_ready <= (state_nxt_s == ST_IDLE);
            rsp_valid <= (state_nxt_s == ST_RESP);
            case (state_r)
                ST_IDLE: begin
                    if (req_valid) begin
                        setflags_r <= req_setflags;
                        if (cond_pass_s) begin
                            alu_a    <= req_a;
                            alu_b    <= req_b;
                            alu_ctrl <= req_op;
                        end else begin
                            rsp_res   <= {N{1'b0}};
                            rsp_exec  <= 1'b0;
                            rsp_flags <= nzcv;
                        end
                    end
                end
                ST_EXEC: begin
                    rsp_res   <= alu_res;
                    rsp_flags <= alu_flags;
                    rsp_exec  <= 1'b1;
                    if (setflags_r) begin
                        nzcv <= alu_flags;
                    end
                end
                default: begin
                end
            endcase
        end
    end

`ifdef ALU_ISSUE_PERF_EN
    // Saturating counters of executed and skipped operations
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_exec <= 16'h0000;
            cnt_skip <= 16'h0000;
        end else begin
            if ((state_r == ST_EXEC) && (cnt_exec != 16'hFFFF)) begin
                cnt_exec <= cnt_exec + 16'h0001;
            end
            if ((state_r == ST_IDLE) && req_valid && !cond_pass_s && (cnt_skip != 16'hFFFF)) begin
                cnt_skip <= cnt_skip + 16'h0001;
            end
        end
    end
`endif

endmodule

// File: tb/tb_alu_issue_ctrl.sv
module tb_alu_issue_ctrl;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_op;
    logic [15:0] req_a;
    logic [15:0] req_b;
    logic [3:0]  req_cond;
    logic        req_setflags;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [15:0] rsp_res;
    logic        rsp_exec;
    logic [3:0]  rsp_flags;
    logic [3:0]  nzcv;
    logic [15:0] alu_a;
    logic [15:0] alu_b;
    logic [2:0]  alu_ctrl;
    logic [15:0] alu_res;
    logic [3:0]  alu_flags;
`ifdef ALU_ISSUE_PERF_EN
    logic [15:0] cnt_exec;
    logic [15:0] cnt_skip;
`endif

    int vectors = 0;
    int miscompares = 0;
    logic [3:0] model_nzcv = 4'b0000;

    alu_issue_ctrl #(.N(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_a(req_a), .req_b(req_b), .req_cond(req_cond), .req_setflags(req_setflags),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_res(rsp_res),
        .rsp_exec(rsp_exec), .rsp_flags(rsp_flags), .nzcv(nzcv),
        .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl),
        .alu_res(alu_res), .alu_flags(alu_flags)
`ifdef ALU_ISSUE_PERF_EN
        , .cnt_exec(cnt_exec), .cnt_skip(cnt_skip)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Behavioural 16-bit ALU: returns {N,Z,C,V, result}
    function automatic logic [19:0] alu_model(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
        logic [16:0] w;
        logic [15:0] r;
        logic c, v;
        c = 1'b0;
        v = 1'b0;
        w = 17'd0;
        case (op)
            3'd0: begin
                w = {1'b0, a} + {1'b0, b};
                r = w[15:0];
                c = w[16];
                v = (a[15] == b[15]) && (r[15] != a[15]);
            end
            3'd1: begin
                w = {1'b0, a} - {1'b0, b};
                r = w[15:0];
                c = ~w[16];
                v = (a[15] != b[15]) && (r[15] != a[15]);
            end
            3'd2: r = a;
            3'd3: r = b;
            3'd4: r = (b == 16'd0) ? a : (a % b);
            3'd5: r = a & b;
            3'd6: r = a * b;
            default: r = a >> b[3:0];
        endcase
        return {r[15], (r == 16'd0), c, v, r};
    endfunction

    assign {alu_flags, alu_res} = alu_model(alu_ctrl, alu_a, alu_b);

    // Reference condition table, one entry per code
    function automatic logic ref_cond(input logic [3:0] cond, input logic [3:0] f);
        logic n, z, c, v;
        {n, z, c, v} = f;
        case (cond)
            4'd0:  return z;
            4'd1:  return !z;
            4'd2:  return c;
            4'd3:  return !c;
            4'd4:  return n;
            4'd5:  return !n;
            4'd6:  return v;
            4'd7:  return !v;
            4'd8:  return c && !z;
            4'd9:  return !c || z;
            4'd10: return n == v;
            4'd11: return n != v;
            4'd12: return !z && (n == v);
            4'd13: return z || (n != v);
            4'd14: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One full transaction, starting and ending at a falling edge in IDLE
    task automatic run_op(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                          input logic [3:0] cond, input logic sf, input int stall, input logic hold_req);
        logic        pass;
        logic [19:0] m;
        logic [15:0] exp_res;
        logic [3:0]  exp_flags;
        logic [15:0] pa, pb;
        logic [2:0]  pc;
        int          lat;
        chk("req_ready_idle", {31'd0, req_ready}, 32'd1);
        pa = alu_a;
        pb = alu_b;
        pc = alu_ctrl;
        pass = ref_cond(cond, model_nzcv);
        m = alu_model(op, a, b);
        req_op = op; req_a = a; req_b = b; req_cond = cond; req_setflags = sf;
        req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        req_a = 16'($urandom);
        lat = 1;
        while (!rsp_valid && lat < 6) begin
            @(negedge clk);
            lat++;
        end
        chk("latency", lat, pass ? 32'd2 : 32'd1);
        chk("req_ready_resp", {31'd0, req_ready}, 32'd0);
        if (pass) begin
            exp_res = m[15:0];
            exp_flags = m[19:16];
            if (sf) model_nzcv = exp_flags;
            chk("alu_a", alu_a, a);
            chk("alu_b", alu_b, b);
            chk("alu_ctrl", alu_ctrl, op);
        end else begin
            exp_res = 16'd0;
            exp_flags = model_nzcv;
            chk("alu_hold", {alu_ctrl, alu_a, alu_b}, {pc, pa, pb});
        end
        chk("rsp_res", rsp_res, exp_res);
        chk("rsp_exec", {31'd0, rsp_exec}, {31'd0, pass});
        chk("rsp_flags", rsp_flags, exp_flags);
        chk("nzcv", nzcv, model_nzcv);
        for (int i = 0; i < stall; i++) begin
            if (hold_req) begin
                req_valid = 1'b1;
                req_a = 16'($urandom);
            end
            @(negedge clk);
            chk("stall_hold", {rsp_valid, req_ready, rsp_exec, rsp_flags, rsp_res},
                {1'b1, 1'b0, pass, exp_flags, exp_res});
            chk("stall_nzcv", nzcv, model_nzcv);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk("after_hs_valid", {31'd0, rsp_valid}, 32'd0);
        chk("after_hs_ready", {31'd0, req_ready}, 32'd1);
        req_valid = 1'b0;
    endtask

    initial begin
        logic [15:0] ra, rb;
        rst_n = 1'b0;
        req_valid = 1'b0; req_op = 3'd0; req_a = 16'd0; req_b = 16'd0;
        req_cond = 4'd0; req_setflags = 1'b0; rsp_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_state", {req_ready, rsp_valid, nzcv, alu_ctrl, rsp_exec, rsp_flags},
            {1'b1, 1'b0, 4'b0000, 3'b000, 1'b0, 4'b0000});
        chk("rst_data", {rsp_res, alu_a}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_ready", {31'd0, req_ready}, 32'd1);

        // Directed steps
        run_op(3'd0, 16'h7FFF, 16'h0001, 4'b1110, 1'b1, 0, 1'b0);
        chk("step2_nzcv", nzcv, 32'h9);
        run_op(3'd0, 16'h1234, 16'h1111, 4'b0000, 1'b1, 0, 1'b0);
        chk("step3_nzcv", nzcv, 32'h9);
        run_op(3'd1, 16'd5, 16'd5, 4'b1110, 1'b1, 0, 1'b0);
        chk("step4_nzcv", nzcv, 32'h6);
        run_op(3'd5, 16'h00F0, 16'h0FF0, 4'b0000, 1'b0, 5, 1'b1);
        chk("step4b_nzcv", nzcv, 32'h6);

        // Reset during EXEC aborts the operation
        req_op = 3'd6; req_a = 16'd3; req_b = 16'd7; req_cond = 4'b1110; req_setflags = 1'b1;
        req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        model_nzcv = 4'b0000;
        chk("rst_exec_nzcv", nzcv, 32'd0);
        chk("rst_exec_flags", {rsp_valid, req_ready, alu_ctrl}, {1'b0, 1'b1, 3'b000});
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_exec_norsp", {rsp_valid, req_ready}, {1'b0, 1'b1});
        end

        // Randomized transactions
        for (int k = 0; k < 40; k++) begin
            ra = 16'($urandom);
            rb = ($urandom_range(0, 3) == 0) ? ra : 16'($urandom);
            run_op(3'($urandom), ra, rb, 4'($urandom), 1'($urandom),
                   $urandom_range(0, 2), 1'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
